uart_tx_mmio: RTL and testbench

//  Memory-mapped UART transmitter on the CPU data-memory bus, downstream of the core's load/store path.
//  A store to TXDATA pushes one byte into a TX FIFO. A serialiser shifts bytes out as 8N1 frames on tx.
//  sel flags an address hit so the core muxes rdata over dataMemory read_data and suppresses its write.

---
 rtl/uart_tx_mmio.sv | 104 ++++++++++
 tb/tb_uart_tx_mmio.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: MMIO 8N1 UART transmitter with TX FIFO (address/write_data/write_en/read_en bus in; sel, read_data, tx, busy out)
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic        write_en,
  input  logic        read_en,
  output logic        sel,
  output logic [31:0] read_data,
  output logic        tx,
  output logic        busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = FIFO_DEPTH[AW:0];
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_nxt;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] count;
  logic [15:0] baud, div_lat, div_lat_nxt, div_cnt, div_cnt_nxt;
  logic [7:0] sh, sh_nxt;
  logic [2:0] bit_cnt, bit_nxt;
  logic [1:0] off;
  logic ovf, full, empty, wr, push, push_ok, pop, tick, tx_nxt, unused_bits;
  assign sel = address[31:4] == BASE_ADDR[31:4];
  assign off = address[3:2];
  assign wr = sel && write_en;
  assign push = wr && off == 2'd0;
  assign full = count == DEPTH;
  assign empty = count == '0;
  assign push_ok = push && (!full || pop);
  assign busy = state != IDLE || !empty;
  assign tick = div_cnt == 16'd0;
  assign unused_bits = ^{address[1:0], write_data[31:16]};
  assign read_data = !(sel && read_en) ? 32'd0 :
                     off == 2'd1 ? {28'd0, ovf, busy, full, empty} :
                     off == 2'd2 ? {16'd0, baud} : 32'd0;
  always_comb begin
    state_nxt = state;
    div_cnt_nxt = tick ? div_lat - 16'd1 : div_cnt - 16'd1;
    div_lat_nxt = div_lat;
    bit_nxt = bit_cnt;
    sh_nxt = sh;
    tx_nxt = tx;
    pop = !empty && (state == IDLE || (state == STOP && tick));
    case (state)
      START: if (tick) begin
        state_nxt = DATA;
        bit_nxt = 3'd0;
        tx_nxt = sh[0];
      end
      DATA: if (tick) begin
        state_nxt = bit_cnt == 3'd7 ? STOP : DATA;
        bit_nxt = bit_cnt + 3'd1;
        sh_nxt = sh >> 1;
        tx_nxt = bit_cnt == 3'd7 ? 1'b1 : sh[1];
      end
      STOP: if (tick) state_nxt = IDLE;
      default: div_cnt_nxt = div_cnt;
    endcase
    if (pop) begin
      state_nxt = START;
      sh_nxt = mem[rptr];
      div_lat_nxt = baud;
      div_cnt_nxt = baud - 16'd1;
      tx_nxt = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      tx <= 1'b1;
      sh <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      div_lat <= '0;
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      ovf <= 1'b0;
      baud <= DEFAULT_DIV;
    end else begin
      state <= state_nxt;
      tx <= tx_nxt;
      sh <= sh_nxt;
      bit_cnt <= bit_nxt;
      div_cnt <= div_cnt_nxt;
      div_lat <= div_lat_nxt;
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      if (push_ok && !pop) count <= count + 1'b1;
      else if (pop && !push_ok) count <= count - 1'b1;
      if (push && !push_ok) ovf <= 1'b1;
      else if (wr && off == 2'd1 && write_data[3]) ovf <= 1'b0;
      if (wr && off == 2'd2) baud <= write_data[15:0] == 16'd0 ? 16'd1 : write_data[15:0];
    end
  end
  always_ff @(posedge clk) if (push_ok) mem[wptr] <= write_data[7:0];
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: directed self-checking bench for uart_tx_mmio
module tb_uart_tx_mmio;
  localparam logic [31:0] TXD = 32'h0001_0000, STS = 32'h0001_0004, BDV = 32'h0001_0008;
  logic clk = 1'b0, rst = 1'b1, write_en = 1'b0, read_en = 1'b0;
  logic [31:0] address = '0, write_data = '0;
  logic sel, tx, busy;
  logic [31:0] read_data, d;
  logic s;
  int checks = 0, errors = 0;
  uart_tx_mmio dut (
    .clk(clk), .rst(rst), .address(address), .write_data(write_data),
    .write_en(write_en), .read_en(read_en), .sel(sel), .read_data(read_data),
    .tx(tx), .busy(busy)
  );
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic bus_write(input logic [31:0] a, input logic [31:0] v);
    @(negedge clk);
    address = a;
    write_data = v;
    write_en = 1'b1;
    @(posedge clk);
    #1 write_en = 1'b0;
  endtask
  task automatic bus_read(input logic [31:0] a, output logic [31:0] v, output logic sl);
    @(negedge clk);
    address = a;
    read_en = 1'b1;
    #1 v = read_data;
    sl = sel;
    read_en = 1'b0;
  endtask
  task automatic sample_frame(input int div, input logic [7:0] b, input string tag);
    for (int k = 0; k < 10 * div; k++) begin
      int idx;
      logic e;
      @(posedge clk);
      #1 idx = k / div;
      e = idx == 0 ? 1'b0 : idx == 9 ? 1'b1 : b[idx-1];
      chk(tag, {31'd0, tx}, {31'd0, e});
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("reset_tx", {31'd0, tx}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    bus_read(STS, d, s);
    chk("reset_status", d, 32'h1);
    bus_read(BDV, d, s);
    chk("reset_baud", d, 32'd434);
    bus_write(BDV, 32'd4);
    bus_write(TXD, 32'hA5);
    chk("t1_tx_still_idle", {31'd0, tx}, 32'd1);
    bus_read(STS, d, s);
    chk("t1_status_queued", d, 32'h4);
    sample_frame(4, 8'hA5, "t1_frame");
    chk("t1_busy_last", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1 chk("t1_busy_fall", {31'd0, busy}, 32'd0);
    chk("t1_tx_idle", {31'd0, tx}, 32'd1);
    bus_write(BDV, 32'd2);
    bus_write(TXD, 32'h3C);
    fork
      begin
        sample_frame(2, 8'h3C, "t2_frame0");
        sample_frame(2, 8'h81, "t2_frame1");
        sample_frame(2, 8'h6E, "t2_frame2");
      end
      begin
        bus_write(TXD, 32'h81);
        bus_write(TXD, 32'h6E);
      end
    join
    @(posedge clk);
    #1 chk("t2_busy_fall", {31'd0, busy}, 32'd0);
    bus_write(BDV, 32'd1000);
    for (int i = 0; i < 17; i++) bus_write(TXD, i);
    bus_read(STS, d, s);
    chk("t3_full_no_ovf", d, 32'h6);
    bus_write(TXD, 32'hEE);
    bus_read(STS, d, s);
    chk("t3_ovf_set", d, 32'hE);
    bus_write(STS, 32'h8);
    bus_read(STS, d, s);
    chk("t3_ovf_clear", d, 32'h6);
    do_reset();
    bus_read(STS, d, s);
    chk("t3_after_reset", d, 32'h1);
    bus_write(BDV, 32'd4);
    bus_write(TXD, 32'h3C);
    fork
      begin
        sample_frame(4, 8'h3C, "t4_frame_div4");
        sample_frame(8, 8'h5A, "t4_frame_div8");
      end
      begin
        repeat (10) @(posedge clk);
        bus_write(BDV, 32'd8);
        bus_write(TXD, 32'h5A);
      end
    join
    bus_read(BDV, d, s);
    chk("t4_baud8", d, 32'd8);
    bus_write(BDV, 32'd0);
    bus_read(BDV, d, s);
    chk("t4_baud0_as1", d, 32'd1);
    do_reset();
    bus_write(BDV, 32'd4);
    bus_write(TXD, 32'h00);
    bus_write(TXD, 32'h11);
    repeat (21) @(posedge clk);
    #1 chk("t5_tx_bit4_low", {31'd0, tx}, 32'd0);
    #2 rst = 1'b1;
    #1 chk("t5_tx_async_high", {31'd0, tx}, 32'd1);
    chk("t5_busy_reset", {31'd0, busy}, 32'd0);
    bus_read(STS, d, s);
    chk("t5_status", d, 32'h1);
    bus_read(BDV, d, s);
    chk("t5_baud", d, 32'd434);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("t5_fifo_discarded", {31'd0, busy}, 32'd0);
    chk("t5_tx_idle", {31'd0, tx}, 32'd1);
    bus_read(32'h0001_0010, d, s);
    chk("t6_sel_above", {31'd0, s}, 32'd0);
    chk("t6_rdata_above", d, 32'd0);
    bus_read(32'h0000_FFFC, d, s);
    chk("t6_sel_below", {31'd0, s}, 32'd0);
    chk("t6_rdata_below", d, 32'd0);
    bus_write(32'h0001_0010, 32'h55);
    bus_write(32'h0000_FFFC, 32'h55);
    bus_write(32'h0001_0018, 32'd7);
    bus_write(32'h0000_FFF8, 32'd7);
    bus_read(32'h0001_0006, d, s);
    chk("t6_sel_hit", {31'd0, s}, 32'd1);
    chk("t6_status_unaligned", d, 32'h1);
    bus_read(BDV, d, s);
    chk("t6_baud_unchanged", d, 32'd434);
    bus_read(32'h0001_000C, d, s);
    chk("t6_reserved_read", d, 32'd0);
    bus_write(32'h0001_000C, 32'hFFFF);
    bus_read(TXD, d, s);
    chk("t6_txdata_read", d, 32'd0);
    @(negedge clk);
    address = STS;
    read_en = 1'b0;
    #1 chk("t6_no_read_en", read_data, 32'd0);
    chk("t6_idle_busy", {31'd0, busy}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
